// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: the occupancy-state
// encoding and the default field widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    localparam int CTRL_W_DEF = 16;
    localparam int REG_W_DEF  = 4;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    // Width of the packed payload bundle: control word, two register
    // indices and six data-width fields.
    function automatic int bund_width(input int ctrl_w, input int reg_w, input int data_w);
        return ctrl_w + 2 * reg_w + 6 * data_w;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Skid register for the pipeline stage: captures an incoming entry when the
// main register is occupied and cannot drain, and hands it back when the main
// register drains. It is driven with state EMPTY when the skid feature is not
// built, which leaves the register permanently idle.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int BUND_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  pipe_state_e       state,
    input  logic              in_xfer,
    input  logic              out_xfer,
    input  logic [BUND_W-1:0] din,
    output logic [BUND_W-1:0] dout,
    output logic              unload
);

    logic              load_p0;
    logic [BUND_W-1:0] skid_p1;

    // A new entry arrives while the main entry is stuck downstream.
    assign load_p0 = (state == ONE) && in_xfer && !out_xfer && !flush;

    // The main entry leaves while the skid holds the next one.
    assign unload  = (state == TWO) && out_xfer && !flush;

    // Skid storage: captures the overflow entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_p1 <= '0;
        end else if (load_p0) begin
            skid_p1 <= din;
        end
    end

    assign dout = skid_p1;

endmodule

// File: rtl/pipe_stage_reg.sv
// One-cycle pipeline stage register with valid/ready handshake, flush and a
// saturating downstream-stall counter.
// Build option: define PIPE_SKID_EN for a two-entry skid buffer with a
// state-derived in_ready; otherwise a single entry whose in_ready passes
// out_ready straight through.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [REG_W-1:0]  in_ra,
    input  logic [REG_W-1:0]  in_rb,
    input  logic [DATA_W-1:0] in_dat_a,
    input  logic [DATA_W-1:0] in_dat_b,
    input  logic [DATA_W-1:0] in_off21,
    input  logic [DATA_W-1:0] in_off_store,
    input  logic [DATA_W-1:0] in_robj,
    input  logic [DATA_W-1:0] in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [REG_W-1:0]  out_ra,
    output logic [REG_W-1:0]  out_rb,
    output logic [DATA_W-1:0] out_dat_a,
    output logic [DATA_W-1:0] out_dat_b,
    output logic [DATA_W-1:0] out_off21,
    output logic [DATA_W-1:0] out_off_store,
    output logic [DATA_W-1:0] out_robj,
    output logic [DATA_W-1:0] out_imm,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int BUND_W    = bund_width(CTRL_W, REG_W, DATA_W);
    localparam int IMM_LSB   = 0;
    localparam int ROBJ_LSB  = IMM_LSB + DATA_W;
    localparam int OFFS_LSB  = ROBJ_LSB + DATA_W;
    localparam int OFF21_LSB = OFFS_LSB + DATA_W;
    localparam int DATB_LSB  = OFF21_LSB + DATA_W;
    localparam int DATA_LSB  = DATB_LSB + DATA_W;
    localparam int RB_LSB    = DATA_LSB + DATA_W;
    localparam int RA_LSB    = RB_LSB + REG_W;
    localparam int CTRL_LSB  = RA_LSB + REG_W;

    // Counter increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    pipe_state_e       state_p1;
    pipe_state_e       skid_state;
    logic [BUND_W-1:0] in_bund_p0;
    logic [BUND_W-1:0] bund_p1;
    logic [BUND_W-1:0] skid_dout;
    logic              skid_unload;
    logic              vld_p1;
    logic              in_xfer;
    logic              out_xfer;
    logic [CNT_W-1:0]  stall_p1;

    assign in_bund_p0 = {in_ctrl, in_ra, in_rb, in_dat_a, in_dat_b,
                         in_off21, in_off_store, in_robj, in_imm};

    assign vld_p1   = (state_p1 != EMPTY);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = vld_p1 && out_ready;

`ifdef PIPE_SKID_EN
    assign in_ready   = (state_p1 != TWO) && !flush && !rst;
    assign skid_state = state_p1;
`else
    assign in_ready   = !rst && !flush && (!vld_p1 || out_ready);
    assign skid_state = EMPTY;
`endif

    pipe_skid_buf #(
        .BUND_W (BUND_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .state    (skid_state),
        .in_xfer  (in_xfer),
        .out_xfer (out_xfer),
        .din      (in_bund_p0),
        .dout     (skid_dout),
        .unload   (skid_unload)
    );

    // Occupancy FSM and main output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1 <= EMPTY;
            bund_p1  <= '0;
        end else if (flush) begin
            state_p1 <= EMPTY;
        end else begin
            case (state_p1)
                EMPTY: begin
                    if (in_xfer) begin
                        bund_p1  <= in_bund_p0;
                        state_p1 <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        bund_p1 <= in_bund_p0;
`ifdef PIPE_SKID_EN
                    end else if (in_xfer) begin
                        state_p1 <= TWO;
`endif
                    end else if (out_xfer) begin
                        state_p1 <= EMPTY;
                    end
                end
                TWO: begin
                    if (skid_unload) begin
                        bund_p1  <= skid_dout;
                        state_p1 <= ONE;
                    end
                end
                default: state_p1 <= EMPTY;
            endcase
        end
    end

    // Stall counter: cycles where an entry waits on downstream; survives flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_p1 <= '0;
        end else if (vld_p1 && !out_ready) begin
            stall_p1 <= sat_inc(stall_p1);
        end
    end

    assign out_valid     = vld_p1;
    assign out_ctrl      = vld_p1 ? bund_p1[CTRL_LSB +: CTRL_W] : '0;
    assign out_ra        = bund_p1[RA_LSB    +: REG_W];
    assign out_rb        = bund_p1[RB_LSB    +: REG_W];
    assign out_dat_a     = bund_p1[DATA_LSB  +: DATA_W];
    assign out_dat_b     = bund_p1[DATB_LSB  +: DATA_W];
    assign out_off21     = bund_p1[OFF21_LSB +: DATA_W];
    assign out_off_store = bund_p1[OFFS_LSB  +: DATA_W];
    assign out_robj      = bund_p1[ROBJ_LSB  +: DATA_W];
    assign out_imm       = bund_p1[IMM_LSB   +: DATA_W];
    assign stall_cnt     = stall_p1;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a queue model of the stage is compared against the
// DUT every cycle, with directed literal checks at key points. Honours
// PIPE_SKID_EN to select the two-entry or single-entry behaviour.
module tb_pipe_stage_reg;

    localparam int CW   = 16;
    localparam int RW   = 4;
    localparam int DW   = 32;
    localparam int NW   = 4;
    localparam int CMAX = (1 << NW) - 1;
`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [RW-1:0] ra;
        logic [RW-1:0] rb;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] off21;
        logic [DW-1:0] offs;
        logic [DW-1:0] robj;
        logic [DW-1:0] imm;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, flush, in_valid, out_ready;
    logic          in_ready, out_valid;
    ent_t          cur_in;
    logic [CW-1:0] out_ctrl;
    logic [RW-1:0] out_ra, out_rb;
    logic [DW-1:0] out_dat_a, out_dat_b, out_off21, out_off_store, out_robj, out_imm;
    logic [NW-1:0] stall_cnt;

    pipe_stage_reg #(.CTRL_W(CW), .REG_W(RW), .DATA_W(DW), .CNT_W(NW)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_ctrl       (cur_in.ctrl),
        .in_ra         (cur_in.ra),
        .in_rb         (cur_in.rb),
        .in_dat_a      (cur_in.a),
        .in_dat_b      (cur_in.b),
        .in_off21      (cur_in.off21),
        .in_off_store  (cur_in.offs),
        .in_robj       (cur_in.robj),
        .in_imm        (cur_in.imm),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_ctrl      (out_ctrl),
        .out_ra        (out_ra),
        .out_rb        (out_rb),
        .out_dat_a     (out_dat_a),
        .out_dat_b     (out_dat_b),
        .out_off21     (out_off21),
        .out_off_store (out_off_store),
        .out_robj      (out_robj),
        .out_imm       (out_imm),
        .stall_cnt     (stall_cnt)
    );

    int   nchk = 0;
    int   nerr = 0;
    bit   chk_en = 1'b0;
    ent_t mq[$];
    ent_t last = '0;
    int   mcnt = 0;

    // Distinct, recognisable payload for entry number i.
    function automatic ent_t mk(input int i);
        ent_t e;
        e.ctrl  = 16'h1000 | 16'(i);
        e.ra    = 4'(i);
        e.rb    = ~4'(i);
        e.a     = 32'(32'hA5A5_0000 + i);
        e.b     = 32'h5A5A_0000 ^ 32'(i);
        e.off21 = 32'(32'h0010_0000 + 3 * i);
        e.offs  = 32'(32'hFFFF_0000 - i);
        e.robj  = 32'hC0DE_0000 | 32'(i);
        e.imm   = 32'h8000_0000 | 32'(i << 4);
        return e;
    endfunction

    // What in_ready must be given the model's occupancy and current inputs.
    function automatic bit exp_rdy();
        if (rst || flush) return 1'b0;
        if (SKID) return mq.size() < 2;
        return (mq.size() == 0) || out_ready;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of accepted entries, capacity 1 or 2.
    always @(posedge clk) begin : model
        bit ir, ov;
        if (rst) begin
            mq.delete();
            last = '0;
            mcnt = 0;
        end else begin
            ir = exp_rdy();
            ov = (mq.size() > 0);
            if (ov && !out_ready && mcnt < CMAX) mcnt++;
            if (flush) begin
                mq.delete();
            end else begin
                if (ov && out_ready) void'(mq.pop_front());
                if (in_valid && ir) mq.push_back(cur_in);
            end
            if (mq.size() > 0) last = mq[0];
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin : cmp
        ent_t e;
        bit   ov;
        if (chk_en) begin
            ov = (mq.size() > 0);
            e  = ov ? mq[0] : last;
            chk("in_ready",      in_ready,      exp_rdy());
            chk("out_valid",     out_valid,     ov);
            chk("out_ctrl",      out_ctrl,      ov ? e.ctrl : '0);
            chk("out_ra",        out_ra,        e.ra);
            chk("out_rb",        out_rb,        e.rb);
            chk("out_dat_a",     out_dat_a,     e.a);
            chk("out_dat_b",     out_dat_b,     e.b);
            chk("out_off21",     out_off21,     e.off21);
            chk("out_off_store", out_off_store, e.offs);
            chk("out_robj",      out_robj,      e.robj);
            chk("out_imm",       out_imm,       e.imm);
            chk("stall_cnt",     stall_cnt,     64'(mcnt));
        end
    end

    task automatic drive(input bit v, input int idx, input bit ordy, input bit fl);
        in_valid  = v;
        cur_in    = mk(idx);
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int  idx;
        bit  acc;
        bit  ordy;

        // Reset held two cycles with an entry offered.
        rst = 1'b1;
        drive(1, 0, 1, 0);
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        drive(0, 0, 1, 0);
        @(negedge clk);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ctrl",  out_ctrl,  0);
        chk("rst_stall_cnt", stall_cnt, 0);

        // Back-to-back streaming, downstream always ready.
        for (int k = 0; k < 8; k++) begin
            drive(1, k, 1, 0);
            step();
            chk("stream_valid", out_valid, 1);
            chk("stream_dat_a", out_dat_a, 64'(32'(32'hA5A5_0000 + k)));
        end
        drive(0, 0, 1, 0);
        step();
        chk("stream_drain", out_valid, 0);

`ifdef PIPE_SKID_EN
        // Three cycles of downstream stall while streaming.
        drive(1, 20, 1, 0);
        step();
        drive(1, 21, 0, 0);
        @(negedge clk);
        chk("bp_rdy_one", in_ready, 1);
        step();
        drive(1, 22, 0, 0);
        @(negedge clk);
        chk("bp_rdy_two", in_ready, 0);
        chk("bp_head",    out_dat_a, 64'(32'hA5A5_0014));
        step();
        drive(1, 22, 0, 0);
        step();
        drive(1, 22, 1, 0);
        @(negedge clk);
        chk("bp_stall3", stall_cnt, 3);
        chk("bp_rdy_drain", in_ready, 0);
        step();
        drive(1, 22, 1, 0);
        step();
        drive(0, 0, 1, 0);
        step();
        step();
        chk("bp_empty", out_valid, 0);
        chk("bp_stall_final", stall_cnt, 3);

        // Flush while both entries are held and a third is offered.
        drive(1, 30, 1, 0);
        step();
        drive(1, 31, 0, 0);
        step();
        drive(1, 32, 0, 1);
        @(negedge clk);
        chk("fl_rdy", in_ready, 0);
        step();
`else
        // out_ready toggling: in_ready tracks it while an entry is held.
        idx = 8;
        for (int c = 0; c < 40 && idx < 16; c++) begin
            ordy = ~c[0];
            drive(1, idx, ordy, 0);
            @(negedge clk);
            if (mq.size() > 0) chk("tog_rdy_follow", in_ready, ordy);
            acc = in_ready;
            step();
            if (acc) idx++;
        end
        chk("tog_all_sent", idx, 16);
        drive(0, 0, 1, 0);
        step();
        step();
        chk("tog_empty", out_valid, 0);

        // Flush while an entry is held and another is offered.
        drive(1, 30, 1, 0);
        step();
        drive(1, 31, 0, 1);
        @(negedge clk);
        chk("fl_rdy", in_ready, 0);
        step();
`endif
        chk("fl_out_valid", out_valid, 0);
        chk("fl_out_ctrl",  out_ctrl,  0);
        drive(1, 33, 1, 0);
        step();
        chk("fl_next_entry", out_dat_a, 64'(32'hA5A5_0021));
        drive(0, 0, 1, 0);
        step();
        step();

        // Reset in mid-stream, together with flush and an offered entry.
        drive(1, 50, 0, 0);
        step();
        drive(1, 51, 1, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(0, 0, 1, 0);
        @(negedge clk);
        chk("mr_out_valid", out_valid, 0);
        chk("mr_in_ready",  in_ready,  1);
        chk("mr_stall_cnt", stall_cnt, 0);
        chk("mr_dat_a",     out_dat_a, 0);

        // Stall counter saturation over 20 stalled cycles.
        drive(1, 60, 1, 0);
        step();
        drive(0, 0, 0, 0);
        repeat (20) step();
        chk("sat_stall_cnt", stall_cnt, 64'(CMAX));
        chk("sat_held_a",    out_dat_a, 64'(32'hA5A5_003C));
        drive(0, 0, 1, 0);
        step();
        step();
        chk("sat_drain", out_valid, 0);
        chk("sat_kept",  stall_cnt, 64'(CMAX));

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  CTRL_W, 16, control-word width.
  REG_W, 4, register-index width.
  DATA_W, 32, operand/offset/immediate width.
  CNT_W, 16, stall-counter width.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk  in  1  single clock, rising edge.
  rst  in  1  synchronous, active-high reset.
  flush  in  1  discard all held entries.
  in_valid  in  1  upstream entry present.
  in_ready  out  1  stage accepts entry this cycle.
  in_ctrl  in  CTRL_W  control word.
  in_ra, in_rb  in  REG_W  source register indices.
  in_dat_a, in_dat_b, in_off21, in_off_store, in_robj, in_imm  in  DATA_W  payload.
  out_valid  out  1  entry presented downstream.
  out_ready  in  1  downstream accepts this cycle.
  out_ctrl, out_ra, out_rb, out_dat_a, out_dat_b, out_off21, out_off_store, out_robj, out_imm  out  matching widths  registered payload.
  stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0.
REQ-003 The single clock SHALL be clk; reset SHALL be synchronous, active-high, named rst.

Function
REQ-004 An input transfer SHALL occur iff in_valid && in_ready on a rising clk edge; an output transfer iff out_valid && out_ready.
REQ-005 Every payload field SHALL be stored at its full declared width; no field truncated.
REQ-006 Latency SHALL be 1 cycle: an entry accepted into an empty stage appears on out_* with out_valid=1 the next cycle.
REQ-007 The occupancy FSM SHALL have states EMPTY, ONE, TWO (TWO only when PIPE_SKID_EN defined).
REQ-008 EMPTY->ONE on input transfer; ONE->EMPTY on output transfer without input transfer; ONE stays ONE on simultaneous input and output transfers, loading the new entry.
REQ-009 With PIPE_SKID_EN, ONE->TWO on input transfer without output transfer (new entry into skid register); TWO->ONE on output transfer (skid moves to main); in_ready SHALL be 0 in TWO.
REQ-010 Entries SHALL leave in acceptance order; out_* SHALL stay stable while out_valid=1 and out_ready=0.
REQ-011 flush SHALL force the next state to EMPTY, clear out_valid, set out_ctrl to 0 (NOP), and force in_ready=0 in the flush cycle; flush overrides simultaneous transfers.
REQ-012 When out_valid=0, out_ctrl SHALL read 0; other payload outputs hold their last value.
REQ-013 stall_cnt SHALL increment by 1 per cycle with out_valid=1 and out_ready=0, saturate at all-ones, and not be cleared by flush.

Reset
REQ-014 While rst=1 the FSM SHALL be EMPTY and, on the following edge, out_valid, in_ready-held state, every out_* payload and stall_cnt SHALL be 0.
REQ-015 rst SHALL take priority over flush and any transfer; reset mid-stream discards all entries.
REQ-016 in_ready SHALL be 0 during rst and 1 in the first cycle after rst deasserts.

Configuration
REQ-017 Macro PIPE_SKID_EN defined: two-entry skid buffer; in_ready SHALL be a registered signal (1 iff state != TWO and no flush/rst), full throughput under single-cycle out_ready drops.
REQ-018 PIPE_SKID_EN undefined: single entry; in_ready SHALL be combinational = !rst && !flush && (!out_valid || out_ready); TWO state absent.

Structure
REQ-019 A shared package pipe_pkg SHALL hold the occupancy-state enum (EMPTY, ONE, TWO) and the default width constants.
REQ-020 Payload SHALL be packed into one bundle vector; a sub-module pipe_skid_buf SHALL hold the skid register and its load/unload control.

Verification
REQ-021 Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, stall_cnt=0, in_ready=1 the cycle after release.
REQ-022 Streaming: out_ready=1, 8 back-to-back entries in_dat_a=0xA5A5_0000+i -> out in order, 1-cycle latency, no bubbles, out_dat_a upper 28 bits intact.
REQ-023 Backpressure (PIPE_SKID_EN): out_ready=0 for 3 cycles during stream -> exactly 2 entries held, in_ready=0 in TWO, no loss/duplication, stall_cnt=3.
REQ-024 Flush in TWO with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, flushed and concurrent entries never appear.
REQ-025 Saturation: CNT_W=4, out_ready=0 for 20 cycles with out_valid=1 -> stall_cnt stops at 15.
REQ-026 PIPE_SKID_EN undefined: out_ready toggling 1/0 -> in_ready follows out_ready same cycle while out_valid=1; order preserved.
